fifo_rd_serializer: RTL
=======================

FIFO_RD_SERIALIZER -- requirements
Module: fifo_rd_serializer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 64, meaning the width of the FIFO word consumed.
REQ-002 SHALL have parameter OUT_WIDTH, default 16, meaning the width of one output beat; RATIO = IN_WIDTH/OUT_WIDTH.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk_i  input  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_i  input  1  synchronous active-high reset.
REQ-006 SHALL have port fifo_rdata_i  input  IN_WIDTH  head word of the upstream sync_fifo, valid while fifo_rempty_i=0.
REQ-007 SHALL have port fifo_rempty_i  input  1  upstream FIFO empty flag.
REQ-008 SHALL have port fifo_rd_en_o  output  1  pop strobe to the upstream FIFO, one word per asserted cycle.
REQ-009 SHALL have port flush_i  input  1  abort the current word and drop its remaining beats.
REQ-010 SHALL have port out_valid_o  output  1  beat valid.
REQ-011 SHALL have port out_ready_i  input  1  downstream accepts the beat.
REQ-012 SHALL have port out_data_o  output  OUT_WIDTH  beat data.
REQ-013 SHALL have port out_last_o  output  1  the current beat is the final beat of its FIFO word.

Function
REQ-014 SHALL support only IN_WIDTH an integer multiple of OUT_WIDTH with RATIO >= 2; other values SHALL stop elaboration.
REQ-015 SHALL implement two states, IDLE and SEND, with a holding register (IN_WIDTH) and a beat counter (clog2(RATIO) bits).
REQ-016 In IDLE with fifo_rempty_i=0 and flush_i=0, SHALL assert fifo_rd_en_o, capture fifo_rdata_i into the holding register, clear the counter and enter SEND.
REQ-017 SHALL give a latency of exactly one cycle from fifo_rempty_i falling, in IDLE, to out_valid_o rising.
REQ-018 In SEND, SHALL drive out_valid_o=1 and out_data_o = holding[cnt*OUT_WIDTH +: OUT_WIDTH], i.e. LSB slice first.
REQ-019 SHALL drive out_last_o=1 only in SEND with cnt = RATIO-1.
REQ-020 SHALL advance a beat only on out_valid_o & out_ready_i; with out_ready_i=0, out_data_o and out_last_o SHALL hold stable.
REQ-021 On a handshake with cnt < RATIO-1, SHALL increment cnt.
REQ-022 On a handshake with cnt = RATIO-1 and fifo_rempty_i=0, SHALL pop and load the next word in the same cycle, clear cnt and remain in SEND, with no idle bubble.
REQ-023 On a handshake with cnt = RATIO-1 and fifo_rempty_i=1, SHALL return to IDLE.
REQ-024 SHALL make fifo_rd_en_o combinational: (IDLE & !rempty & !flush) | (SEND & handshake & last & !rempty & !flush).
REQ-025 SHALL never assert fifo_rd_en_o while fifo_rempty_i=1.
REQ-026 SHALL assert fifo_rd_en_o at most once per word, with no underflow or duplicate pops.
REQ-027 On flush_i=1 in any state, SHALL go to IDLE next cycle and suppress fifo_rd_en_o that cycle; a beat handshaken in that same cycle counts as delivered.
REQ-028 SHALL give flush_i priority over load, pop and counter advance.
REQ-029 SHALL sustain a throughput of one beat per cycle while out_ready_i=1 and the FIFO is non-empty.
REQ-030 SHALL make out_valid_o, out_last_o and out_data_o depend only on registered state, with no combinational path from out_ready_i.

Reset
REQ-031 On reset_i=1 at a clock edge, SHALL set the state to IDLE, cnt=0 and the holding register to 0.
REQ-032 During reset, SHALL hold out_valid_o=0, out_last_o=0, out_data_o=0 and fifo_rd_en_o=0.
REQ-033 SHALL treat reset asserted mid-word like a flush: remaining beats are lost and no pop is issued in the reset cycle.

Structure
REQ-034 SHALL place state encodings (IDLE=1'b0, SEND=1'b1) in shared package fifo_rd_serializer_pkg; RATIO and the counter width SHALL be local constants.
REQ-035 SHALL have no sub-module; the block instantiates beside sync_fifo, with fifo_* ports wired to rd_en_i, rdata_o and rempty_o.

Verification (IN=64, OUT=16)
REQ-036 SHALL verify: push 0x4444_3333_2222_1111, out_ready=1 -> beats 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles, last only on 0x4444, a single pop.
REQ-037 SHALL verify: FIFO holds 3 words, out_ready=1 -> 12 contiguous valid beats, pops on cycles 0, 4 and 8, then IDLE.
REQ-038 SHALL verify: out_ready toggles 1,0,0,1 at beat 1 -> 0x2222 held stable for 3 cycles, no extra pop.
REQ-039 SHALL verify: flush at beat 2 with 1 word queued -> valid drops next cycle, next cycle pops the queued word, first beat is its LSB slice.
REQ-040 SHALL verify: reset pulse mid-word -> all outputs 0, no pop in the reset cycle; a random push/ready soak matches the scoreboard.

Source files
------------

// File: rtl/fifo_rd_serializer_pkg.sv
// Shared types for the FIFO read-side word-to-beat serializer.
package fifo_rd_serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/fifo_rd_serializer.sv
// Pops IN_WIDTH words from a sync_fifo and emits them as RATIO beats of
// OUT_WIDTH bits, least-significant slice first, with back-to-back reload.
module fifo_rd_serializer
  import fifo_rd_serializer_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 64,
  parameter int unsigned OUT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [IN_WIDTH-1:0]  fifo_rdata_i,
  input  logic                 fifo_rempty_i,
  output logic                 fifo_rd_en_o,
  input  logic                 flush_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [OUT_WIDTH-1:0] out_data_o,
  output logic                 out_last_o
);

  localparam int unsigned RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int unsigned CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

  if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_ratio
    $error("fifo_rd_serializer: IN_WIDTH must be an integer multiple (>=2) of OUT_WIDTH");
  end

  state_e               state_q, state_d;
  logic [IN_WIDTH-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 hs_c;
  logic                 last_c;
  logic                 load_c;

  assign hs_c   = (state_q == SEND) && out_ready_i;
  assign last_c = (state_q == SEND) && (cnt_q == CNT_LAST);

  // Pop when idle, or when the final beat of the current word is accepted.
  assign load_c = !reset_i && !flush_i && !fifo_rempty_i &&
                  ((state_q == IDLE) || (hs_c && last_c));

  assign fifo_rd_en_o = load_c;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (load_c) begin
      state_d = SEND;
      hold_d  = fifo_rdata_i;
      cnt_d   = '0;
    end else if (hs_c && last_c) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (hs_c) begin
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  // Beat outputs decode registered state only; reset forces them low.
  assign out_valid_o = !reset_i && (state_q == SEND);
  assign out_last_o  = out_valid_o && (cnt_q == CNT_LAST);
  assign out_data_o  = out_valid_o ? hold_q[32'(cnt_q) * OUT_WIDTH +: OUT_WIDTH]
                                   : '0;

endmodule
